return_address_stack: RTL and testbench
=======================================

RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the address width.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of stack entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port i_clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port i_rst  input  1  meaning reset; reset SHALL be synchronous and active-high.
REQ-005 The module SHALL have port i_valid  input  1  meaning the instruction on the update inputs is valid this cycle.
REQ-006 The module SHALL have port i_is_ras_call  input  1  meaning push: a JAL or JALR with rd in {x1, x5}.
REQ-007 The module SHALL have port i_is_ras_return  input  1  meaning pop: a JALR with rs1 in {x1, x5}, rd = x0 and imm = 0.
REQ-008 The module SHALL have port i_link_address  input  XLEN  meaning the value to push (PC+4 of the call).
REQ-009 The module SHALL have port i_restore  input  1  meaning restore the pointer and count from a checkpoint (mispredict or flush).
REQ-010 The module SHALL have port i_restore_ptr  input  $clog2(DEPTH)  meaning the checkpointed top-of-stack index.
REQ-011 The module SHALL have port i_restore_count  input  $clog2(DEPTH+1)  meaning the checkpointed occupancy.
REQ-012 The module SHALL have port o_predict_valid  output  1  meaning the stack is non-empty, so a return prediction is available.
REQ-013 The module SHALL have port o_predicted_target  output  XLEN  meaning the top-of-stack address.
REQ-014 The module SHALL have port o_checkpoint_ptr  output  $clog2(DEPTH)  meaning the current top-of-stack index, for snapshotting.
REQ-015 The module SHALL have port o_checkpoint_count  output  $clog2(DEPTH+1)  meaning the current occupancy, for snapshotting.

Function
REQ-016 The state SHALL consist of the entry array stack[DEPTH], tos_ptr and count; tos_ptr SHALL index the most recently pushed entry.
REQ-017 o_predict_valid SHALL equal (count != 0); o_predicted_target SHALL be stack[tos_ptr] when count != 0 and 0 otherwise; both SHALL be driven combinationally from registered state.
REQ-018 o_checkpoint_ptr SHALL equal tos_ptr and o_checkpoint_count SHALL equal count.
REQ-019 Every update SHALL be visible on the outputs in the cycle after the qualifying edge (one-cycle latency); there SHALL be no combinational path from the update inputs to the outputs.
REQ-020 A push (i_valid && call && !return) SHALL do the following in one edge:
- write stack[tos_ptr+1 mod DEPTH] <= i_link_address;
- set tos_ptr <= tos_ptr+1 mod DEPTH;
- set count <= min(count+1, DEPTH).
REQ-021 On overflow (push when count == DEPTH), the oldest entry SHALL be overwritten circularly and count SHALL stay at DEPTH.
REQ-022 A pop (i_valid && return && !call) with count > 0 SHALL set tos_ptr <= tos_ptr-1 mod DEPTH and count <= count-1.
REQ-023 A pop with count == 0 (underflow) SHALL leave all state unchanged.
REQ-024 A pop-then-push (i_valid && call && return) SHALL write stack[tos_ptr] <= i_link_address, keep tos_ptr unchanged and set count <= max(count, 1).
REQ-025 When i_valid is 0, or both call and return are 0, there SHALL be no state change.
REQ-026 i_restore SHALL load tos_ptr <= i_restore_ptr and count <= i_restore_count, and SHALL leave entry contents untouched.
REQ-027 When i_restore and a valid update occur in the same cycle, i_restore SHALL win and the update SHALL be dropped.
REQ-028 An i_restore_count value greater than DEPTH SHALL be saturated to DEPTH.

Reset
REQ-029 While i_rst is high, tos_ptr and count SHALL be set to 0, and i_rst SHALL take priority over i_restore and all updates.
REQ-030 After reset, the outputs SHALL be: o_predict_valid=0, o_predicted_target=0, o_checkpoint_ptr=0, o_checkpoint_count=0.
REQ-031 Entry storage SHALL NOT be reset.
REQ-032 Reset asserted mid-sequence SHALL discard all pending stack state within the same edge.

Verification
REQ-033 Push 0x100, then push 0x200 -> next cycle target=0x200, count=2, valid=1; pop -> target=0x100, count=1.
REQ-034 From empty, pop -> valid=0, target=0, count=0, ptr=0, all unchanged.
REQ-035 With DEPTH=8, push 0x10..0x90 (9 pushes) -> count=8, target=0x90; then 8 pops -> the last target seen before empty SHALL be 0x20, not 0x10.
REQ-036 With stack {0x100, 0x200}, assert call+return with link 0x300 -> target=0x300, count=2; pop -> target=0x100.
REQ-037 Snapshot ptr=1/count=1, then push 0x400 and push 0x500, then assert i_restore with ptr=1/count=1 concurrently with a push -> target equals the pre-snapshot top, count=1.
REQ-038 With count=3, assert i_rst concurrently with a push -> next cycle count=0, valid=0, ptr=0.

Source files
------------

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return address stack with checkpoint restore
module return_address_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic                       i_is_ras_call,
    input  logic                       i_is_ras_return,
    input  logic [XLEN-1:0]            i_link_address,
    input  logic                       i_restore,
    input  logic [$clog2(DEPTH)-1:0]   i_restore_ptr,
    input  logic [$clog2(DEPTH+1)-1:0] i_restore_count,
    output logic                       o_predict_valid,
    output logic [XLEN-1:0]            o_predicted_target,
    output logic [$clog2(DEPTH)-1:0]   o_checkpoint_ptr,
    output logic [$clog2(DEPTH+1)-1:0] o_checkpoint_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] tos_ptr;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    // Restore beats any update in the same cycle; the update is simply dropped.
    always_comb begin
        ptr_next   = tos_ptr;
        count_next = count;
        wr_en      = 1'b0;
        wr_addr    = tos_ptr;
        if (i_restore) begin
            ptr_next   = i_restore_ptr;
            count_next = (i_restore_count > FULL) ? FULL : i_restore_count;
        end else if (i_valid) begin
            case ({i_is_ras_call, i_is_ras_return})
                2'b10: begin
                    wr_en      = 1'b1;
                    wr_addr    = tos_ptr + PTR_W'(1);
                    ptr_next   = tos_ptr + PTR_W'(1);
                    count_next = (count == FULL) ? count : count + CNT_W'(1);
                end
                2'b01: begin
                    if (count != '0) begin
                        ptr_next   = tos_ptr - PTR_W'(1);
                        count_next = count - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Pop-then-push collapses to replacing the top entry in place.
                    wr_en      = 1'b1;
                    wr_addr    = tos_ptr;
                    count_next = (count == '0) ? CNT_W'(1) : count;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tos_ptr <= '0;
            count   <= '0;
        end else begin
            tos_ptr <= ptr_next;
            count   <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_en) begin
            stack[wr_addr] <= i_link_address;
        end
    end

    assign o_predict_valid    = (count != '0);
    assign o_predicted_target = (count != '0) ? stack[tos_ptr] : '0;
    assign o_checkpoint_ptr   = tos_ptr;
    assign o_checkpoint_count = count;

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed self-checking bench for return_address_stack
module tb_return_address_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] link = '0;
    logic        restore = 1'b0;
    logic [2:0]  restore_ptr = '0;
    logic [3:0]  restore_count = '0;
    logic        predict_valid;
    logic [31:0] predicted_target;
    logic [2:0]  checkpoint_ptr;
    logic [3:0]  checkpoint_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    return_address_stack #(.XLEN(32), .DEPTH(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_valid            (valid),
        .i_is_ras_call      (call),
        .i_is_ras_return    (ret),
        .i_link_address     (link),
        .i_restore          (restore),
        .i_restore_ptr      (restore_ptr),
        .i_restore_count    (restore_count),
        .o_predict_valid    (predict_valid),
        .o_predicted_target (predicted_target),
        .o_checkpoint_ptr   (checkpoint_ptr),
        .o_checkpoint_count (checkpoint_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic v, input logic [31:0] tgt,
                               input logic [2:0] p, input logic [3:0] c);
        check({tag, ".valid"},  32'(predict_valid),    32'(v));
        check({tag, ".target"}, predicted_target,      tgt);
        check({tag, ".ptr"},    32'(checkpoint_ptr),   32'(p));
        check({tag, ".count"},  32'(checkpoint_count), 32'(c));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        valid   = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        restore = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic push(input logic [31:0] a);
        valid = 1'b1; call = 1'b1; ret = 1'b0; link = a;
        step();
    endtask

    task automatic pop();
        valid = 1'b1; call = 1'b0; ret = 1'b1;
        step();
    endtask

    task automatic do_restore(input logic [2:0] p, input logic [3:0] c);
        restore = 1'b1; restore_ptr = p; restore_count = c;
        step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_state("reset", 1'b0, 32'h0, 3'd0, 4'd0);

        push(32'h100);
        push(32'h200);
        check_state("push2", 1'b1, 32'h200, 3'd2, 4'd2);
        pop();
        check_state("pop1", 1'b1, 32'h100, 3'd1, 4'd1);
        pop();
        check_state("pop_to_empty", 1'b0, 32'h0, 3'd0, 4'd0);
        pop();
        check_state("underflow", 1'b0, 32'h0, 3'd0, 4'd0);

        push(32'h100);
        push(32'h200);
        valid = 1'b1; call = 1'b1; ret = 1'b1; link = 32'h300;
        step();
        check_state("call_ret", 1'b1, 32'h300, 3'd2, 4'd2);
        valid = 1'b0; call = 1'b1; link = 32'hdead;
        step();
        check_state("invalid_idle", 1'b1, 32'h300, 3'd2, 4'd2);
        valid = 1'b1; call = 1'b0; ret = 1'b0;
        step();
        check_state("no_op", 1'b1, 32'h300, 3'd2, 4'd2);
        pop();
        check_state("call_ret_pop", 1'b1, 32'h100, 3'd1, 4'd1);

        push(32'h400);
        push(32'h500);
        check_state("pre_restore", 1'b1, 32'h500, 3'd3, 4'd3);
        restore = 1'b1; restore_ptr = 3'd1; restore_count = 4'd1;
        valid = 1'b1; call = 1'b1; link = 32'h600;
        step();
        check_state("restore_wins", 1'b1, 32'h100, 3'd1, 4'd1);
        do_restore(3'd2, 4'd2);
        check_state("restore_contents", 1'b1, 32'h400, 3'd2, 4'd2);
        do_restore(3'd3, 4'd15);
        check_state("restore_sat", 1'b1, 32'h500, 3'd3, 4'd8);

        do_restore(3'd3, 4'd3);
        rst = 1'b1; valid = 1'b1; call = 1'b1; link = 32'h700;
        step();
        check_state("rst_with_push", 1'b0, 32'h0, 3'd0, 4'd0);

        for (int k = 1; k <= 9; k++) push(32'(k * 16));
        check_state("overflow", 1'b1, 32'h90, 3'd1, 4'd8);
        for (int j = 1; j <= 7; j++) begin
            pop();
            check("overflow_pop.target", predicted_target, 32'h90 - 32'(j * 16));
        end
        check_state("last_entry", 1'b1, 32'h20, 3'd2, 4'd1);
        pop();
        check_state("drained", 1'b0, 32'h0, 3'd1, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
